cgra_context_scheduler: RTL and testbench

Sequences kernel execution on the CGRA by driving the configuration loader and array start/done handshakes from a small queue of kernel descriptors. Each descriptor names a bitstream (address, frame count) and a tag. For each descriptor the block loads the context, waits for load completion, starts the array, waits for execution done, then reports completion status. It sits between the control unit / host register file and the config loader plus array control.

---
 rtl/cgra_context_scheduler.sv | 176 +++++++++++++++++
 tb/tb_cgra_context_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_context_scheduler.sv
// Kernel context scheduler: queues descriptors, drives the config loader,
// starts the array and reports per-kernel completion status.
module cgra_context_scheduler #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned LOAD_TIMEOUT = 4096,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               flush,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic [ADDR_WIDTH-1:0]              desc_addr,
  input  logic [15:0]                        desc_frames,
  input  logic [7:0]                         desc_id,
  output logic                               ldr_start,
  output logic [ADDR_WIDTH-1:0]              ldr_addr,
  output logic [15:0]                        ldr_size,
  input  logic                               ldr_done,
  input  logic                               ldr_error,
  output logic                               exec_start,
  output logic [7:0]                         exec_id,
  input  logic                               exec_done,
  output logic                               busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               cmpl_valid,
  output logic [7:0]                         cmpl_id,
  output logic [1:0]                         cmpl_status,
  output logic [CNT_WIDTH-1:0]               kernels_done
);

  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_QW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned TMR_W  = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam int unsigned ENT_W  = ADDR_WIDTH + 16 + 8;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_LOAD_ER = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    EXEC_START,
    EXEC_WAIT,
    COMPLETE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [ENT_W-1:0]   mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   head;
  logic               push;
  logic               pop;

  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign desc_ready = (queue_count < CNT_QW'(QUEUE_DEPTH)) && !flush;
  assign push       = desc_valid && desc_ready;
  assign pop        = (state == IDLE) && enable && (queue_count != '0) && !flush;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {desc_id, desc_frames, desc_addr};
    end
  end

  // Descriptor FIFO bookkeeping; flush drops everything not yet dispatched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  // Kernel sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      ldr_start    <= 1'b0;
      ldr_addr     <= '0;
      ldr_size     <= '0;
      exec_id      <= '0;
      exec_start   <= 1'b0;
      busy         <= 1'b0;
      cmpl_valid   <= 1'b0;
      cmpl_id      <= '0;
      cmpl_status  <= '0;
      kernels_done <= '0;
    end else begin
      exec_start  <= 1'b0;
      cmpl_valid  <= 1'b0;
      cmpl_id     <= '0;
      cmpl_status <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= LOAD_WAIT;
            busy      <= 1'b1;
            timer     <= '0;
            ldr_start <= 1'b1;
            ldr_addr  <= head[ADDR_WIDTH-1:0];
            ldr_size  <= head[ADDR_WIDTH +: 16];
            exec_id   <= head[ADDR_WIDTH+16 +: 8];
          end
        end
        LOAD_WAIT: begin
          if (ldr_error) begin
            ldr_start   <= 1'b0;
            cmpl_valid  <= 1'b1;
            cmpl_id     <= exec_id;
            cmpl_status <= ST_LOAD_ER;
            state       <= COMPLETE;
          end else if (ldr_done) begin
            ldr_start  <= 1'b0;
            exec_start <= 1'b1;
            state      <= EXEC_START;
          end else if (timer == TMR_W'(LOAD_TIMEOUT - 1)) begin
            ldr_start   <= 1'b0;
            cmpl_valid  <= 1'b1;
            cmpl_id     <= exec_id;
            cmpl_status <= ST_TIMEOUT;
            state       <= COMPLETE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EXEC_START: begin
          state <= EXEC_WAIT;
        end
        EXEC_WAIT: begin
          if (exec_done) begin
            cmpl_valid  <= 1'b1;
            cmpl_id     <= exec_id;
            cmpl_status <= ST_OK;
            state       <= COMPLETE;
          end
        end
        COMPLETE: begin
          if ((cmpl_status == ST_OK) && (kernels_done != '1)) begin
            kernels_done <= kernels_done + 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_context_scheduler.sv
// Self-checking bench for cgra_context_scheduler: directed scenarios plus a
// randomized phase scored against a queue-based reference model.
module tb_cgra_context_scheduler;

  localparam int unsigned AW = 32;
  localparam int unsigned QD = 4;
  localparam int unsigned LT = 16;
  localparam int unsigned CW = 4;
  localparam int KD_MAX = 15;
  localparam int M_OK = 0;
  localparam int M_ER = 1;
  localparam int M_TO = 2;

  logic          clk = 1'b0;
  logic          rst_n, enable, flush, desc_valid, desc_ready;
  logic [AW-1:0] desc_addr;
  logic [15:0]   desc_frames;
  logic [7:0]    desc_id;
  logic          ldr_start;
  logic [AW-1:0] ldr_addr;
  logic [15:0]   ldr_size;
  logic          ldr_done, ldr_error, exec_start;
  logic [7:0]    exec_id;
  logic          exec_done, busy;
  logic [2:0]    queue_count;
  logic          cmpl_valid;
  logic [7:0]    cmpl_id;
  logic [1:0]    cmpl_status;
  logic [CW-1:0] kernels_done;

  always #5 clk = ~clk;

  cgra_context_scheduler #(
    .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .LOAD_TIMEOUT(LT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_frames(desc_frames), .desc_id(desc_id),
    .ldr_start(ldr_start), .ldr_addr(ldr_addr), .ldr_size(ldr_size),
    .ldr_done(ldr_done), .ldr_error(ldr_error),
    .exec_start(exec_start), .exec_id(exec_id), .exec_done(exec_done),
    .busy(busy), .queue_count(queue_count),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_status(cmpl_status),
    .kernels_done(kernels_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   frames;
    logic [7:0]    id;
  } desc_t;

  int    tests = 0;
  int    fails = 0;
  desc_t model_q[$];
  int    mode_by_id [256];
  int    ld_by_id   [256];
  int    ed_by_id   [256];
  int    kd_model = 0;
  int    cmpl_ids[$];
  int    cmpl_st[$];
  desc_t inflight;
  bit    inflight_v = 0;
  bit    env_exec_active = 0;
  logic [7:0] nid = 8'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Loader / array responder and completion scoreboard, sampled 1ns after the edge.
  initial begin : env
    logic prev_ls, prev_es, fired, ex_act;
    int   hi, lc, ec, ed, m;
    desc_t d;
    prev_ls = 0; prev_es = 0; fired = 0; ex_act = 0;
    hi = 0; lc = 0; ec = 0; ed = 0;
    ldr_done = 0; ldr_error = 0; exec_done = 0;
    forever begin
      @(posedge clk); #1;
      ldr_done = 0; ldr_error = 0; exec_done = 0;
      if (ldr_start && !prev_ls) begin
        chk("dispatch_nonempty", 64'(model_q.size() != 0), 1);
        if (model_q.size() != 0) begin
          d = model_q.pop_front();
          chk("ldr_addr", ldr_addr, d.addr);
          chk("ldr_size", ldr_size, d.frames);
          chk("exec_id", exec_id, d.id);
          inflight = d;
          inflight_v = 1;
        end
        hi = 0; lc = 0; fired = 0;
      end
      if (ldr_start) begin
        hi++;
        m = mode_by_id[exec_id];
        if (m != M_TO && !fired && lc == ld_by_id[exec_id]) begin
          ldr_done = 1;
          ldr_error = (m == M_ER);
          fired = 1;
        end
        lc++;
      end
      if (!ldr_start && prev_ls)
        chk("ldr_start_len", hi,
            (mode_by_id[exec_id] == M_TO) ? LT : ld_by_id[exec_id] + 1);
      if (ex_act) begin
        if (ec == ed) begin exec_done = 1; ex_act = 0; end
        else ec++;
      end
      if (exec_start) begin
        chk("exec_start_pulse", prev_es, 0);
        chk("exec_start_mode", mode_by_id[exec_id], M_OK);
        ex_act = 1; ec = 0; ed = ed_by_id[exec_id];
      end
      env_exec_active = ex_act;
      if (cmpl_valid) begin
        chk("cmpl_inflight", inflight_v, 1);
        chk("cmpl_id", cmpl_id, inflight.id);
        chk("cmpl_status", cmpl_status, mode_by_id[inflight.id]);
        chk("cmpl_ldr_low", ldr_start, 0);
        cmpl_ids.push_back(int'(cmpl_id));
        cmpl_st.push_back(int'(cmpl_status));
        if (mode_by_id[inflight.id] == M_OK && kd_model < KD_MAX) kd_model++;
        inflight_v = 0;
      end
      prev_ls = ldr_start;
      prev_es = exec_start;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #2;
    chk("queue_count", queue_count, model_q.size());
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [15:0] f, input int m,
                      input int ld, input int ed, output bit acc, output logic [7:0] pid);
    pid = nid;
    nid = nid + 8'd1;
    mode_by_id[pid] = m; ld_by_id[pid] = ld; ed_by_id[pid] = ed;
    desc_valid = 1; desc_addr = a; desc_frames = f; desc_id = pid;
    #1;
    acc = (model_q.size() < QD) && !flush;
    chk("desc_ready", desc_ready, acc);
    if (acc) model_q.push_back('{a, f, pid});
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || (enable && model_q.size() != 0)) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_bound"}, 64'(n < budget), 1);
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ldr_start"}, ldr_start, 0);
    chk({tag, "_ldr_addr"}, ldr_addr, 0);
    chk({tag, "_ldr_size"}, ldr_size, 0);
    chk({tag, "_exec_start"}, exec_start, 0);
    chk({tag, "_exec_id"}, exec_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmpl_valid"}, cmpl_valid, 0);
    chk({tag, "_cmpl_id"}, cmpl_id, 0);
    chk({tag, "_cmpl_status"}, cmpl_status, 0);
    chk({tag, "_kernels_done"}, kernels_done, 0);
    chk({tag, "_desc_ready"}, desc_ready, 1);
  endtask

  initial begin : main
    bit         acc;
    logic [7:0] pid;
    logic [7:0] ids [4];
    int         n, r, m, guard;

    rst_n = 0; enable = 0; flush = 0; desc_valid = 0;
    desc_addr = '0; desc_frames = '0; desc_id = '0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1;
    tick();

    // Single kernel with latency check.
    enable = 1;
    push(32'h1000, 16'd16, M_OK, 10, 10, acc, pid);
    desc_valid = 0;
    chk("t1_ldr_start_n1", ldr_start, 0);
    tick();
    chk("t1_ldr_start_n2", ldr_start, 1);
    chk("t1_busy", busy, 1);
    cmpl_ids.delete(); cmpl_st.delete();
    wait_idle("t1", 200);
    chk("t1_ncmpl", cmpl_ids.size(), 1);
    if (cmpl_ids.size() == 1) begin
      chk("t1_id", cmpl_ids[0], pid);
      chk("t1_status", cmpl_st[0], 0);
    end
    chk("t1_kd", kernels_done, 1);

    // Full queue with dispatch held off.
    enable = 0;
    cmpl_ids.delete(); cmpl_st.delete();
    for (int i = 0; i < 5; i++) begin
      push($urandom, 16'(i + 1), M_OK, i, i + 1, acc, pid);
      if (i < 4) ids[i] = pid;
    end
    chk("t2_full_ready", desc_ready, 0);
    chk("t2_full_count", queue_count, 4);
    desc_valid = 0;
    enable = 1;
    wait_idle("t2", 400);
    chk("t2_ncmpl", cmpl_ids.size(), 4);
    for (int i = 0; i < 4 && i < cmpl_ids.size(); i++) chk("t2_order", cmpl_ids[i], ids[i]);
    chk("t2_kd", kernels_done, 5);

    // Load error (error and done together) followed by a good kernel.
    enable = 0;
    cmpl_ids.delete(); cmpl_st.delete();
    push(32'hA000, 16'd4, M_ER, 3, 0, acc, ids[0]);
    push(32'hB000, 16'd5, M_OK, 2, 3, acc, ids[1]);
    desc_valid = 0;
    enable = 1;
    wait_idle("t3", 200);
    chk("t3_ncmpl", cmpl_ids.size(), 2);
    if (cmpl_ids.size() == 2) begin
      chk("t3_err_status", cmpl_st[0], 1);
      chk("t3_next_id", cmpl_ids[1], ids[1]);
      chk("t3_next_status", cmpl_st[1], 0);
    end
    chk("t3_kd", kernels_done, 6);

    // Load timeout.
    cmpl_ids.delete(); cmpl_st.delete();
    push(32'hC000, 16'd7, M_TO, 0, 0, acc, pid);
    desc_valid = 0;
    wait_idle("t4", 200);
    chk("t4_ncmpl", cmpl_ids.size(), 1);
    if (cmpl_ids.size() == 1) chk("t4_status", cmpl_st[0], 2);
    chk("t4_kd", kernels_done, 6);

    // Flush with one kernel in flight and three queued.
    enable = 0;
    cmpl_ids.delete(); cmpl_st.delete();
    push(32'hD000, 16'd8, M_OK, 2, 30, acc, ids[0]);
    for (int i = 1; i < 4; i++) push($urandom, 16'd9, M_OK, 1, 1, acc, ids[i]);
    desc_valid = 0;
    enable = 1;
    n = 0;
    while (!ldr_start && n < 10) begin tick(); n++; end
    chk("t5_dispatch_bound", 64'(n < 10), 1);
    chk("t5_count_before", queue_count, 3);
    flush = 1;
    model_q.delete();
    #1;
    chk("t5_flush_ready", desc_ready, 0);
    tick();
    flush = 0;
    chk("t5_count_after", queue_count, 0);
    wait_idle("t5", 300);
    chk("t5_ncmpl", cmpl_ids.size(), 1);
    if (cmpl_ids.size() == 1) begin
      chk("t5_id", cmpl_ids[0], ids[0]);
      chk("t5_status", cmpl_st[0], 0);
    end
    chk("t5_kd", kernels_done, 7);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      flush = 0;
      desc_valid = 0;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        flush = 1;
        model_q.delete();
        tick();
      end else if (r < 45) begin
        r = $urandom_range(0, 99);
        m = (r < 70) ? M_OK : (r < 85) ? M_ER : M_TO;
        push($urandom, 16'($urandom_range(1, 65535)), m, $urandom_range(0, 12),
             $urandom_range(0, 8), acc, pid);
      end else begin
        tick();
      end
      if ($urandom_range(0, 9) == 0) enable = ~enable;
    end
    flush = 0; desc_valid = 0; enable = 1;
    wait_idle("rand", 3000);
    chk("rand_kd", kernels_done, kd_model);
    chk("rand_q_empty", queue_count, 0);

    // Counter saturation.
    guard = 0;
    while (kd_model < KD_MAX && guard < 40) begin
      push($urandom, 16'd1, M_OK, 0, 0, acc, pid);
      desc_valid = 0;
      wait_idle("sat_fill", 200);
      guard++;
    end
    chk("sat_kd", kernels_done, KD_MAX);
    push($urandom, 16'd1, M_OK, 0, 0, acc, pid);
    desc_valid = 0;
    wait_idle("sat_hold", 200);
    chk("sat_kd_hold", kernels_done, KD_MAX);

    // Reset in EXEC_WAIT; the late exec_done must be ignored.
    cmpl_ids.delete(); cmpl_st.delete();
    push(32'hE000, 16'd3, M_OK, 2, 40, acc, pid);
    desc_valid = 0;
    n = 0;
    while (!env_exec_active && n < 40) begin tick(); n++; end
    chk("t6_exec_bound", 64'(n < 40), 1);
    tick();
    rst_n = 0;
    model_q.delete();
    inflight_v = 0;
    kd_model = 0;
    tick();
    chk_reset_outputs("t6");
    rst_n = 1;
    for (int i = 0; i < 50; i++) tick();
    chk("t6_late_done_sent", env_exec_active, 0);
    chk("t6_no_cmpl", cmpl_ids.size(), 0);
    chk("t6_busy", busy, 0);
    chk("t6_kd", kernels_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
